// File: rtl/phrase_sequencer.sv
// phrase_sequencer: steps through song positions at a fixed tempo,
// reads the phrase-ID table and strobes coherent phrase_id/step pairs.
//
// Ports:
//   clk, rst        - clock, asynchronous active-high reset
//   start           - level, begins playback from IDLE
//   pause           - level, freezes the tempo prescaler while playing
//   db_entry[4:0]   - table phrase ID for the current address (comb.)
//   address[7:0]    - song position driven to the table
//   phrase_id[4:0]  - captured phrase ID
//   step[3:0]       - step within the current phrase
//   step_tick       - 1-cycle strobe, phrase_id/step new and coherent
//   playing         - high in PRIME or PLAY
//   done            - 1-cycle pulse at end of song
//
// Optional: define PHRASE_SEQ_LOOP_EN to loop back to LOOP_ADDR
// at end of song instead of returning to IDLE.

module phrase_sequencer #(
    parameter int TICK_DIV         = 12500,
    parameter int STEPS_PER_PHRASE = 16,
    parameter int LAST_ADDR        = 152,
    parameter int LOOP_ADDR        = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       pause,
    input  logic [4:0] db_entry,
    output logic [7:0] address,
    output logic [4:0] phrase_id,
    output logic [3:0] step,
    output logic       step_tick,
    output logic       playing,
    output logic       done
);

    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);
    localparam logic [3:0] STEP_MAX = 4'(STEPS_PER_PHRASE - 1);
    localparam logic [7:0] LAST_A = 8'(LAST_ADDR);
`ifdef PHRASE_SEQ_LOOP_EN
    localparam logic [7:0] LOOP_A = 8'(LOOP_ADDR);
`endif

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PRIME = 2'd1,
        PLAY  = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [7:0]    address_q, address_d;
    logic [4:0]    phrase_id_q, phrase_id_d;
    logic [3:0]    step_q, step_d;
    logic          step_tick_q, step_tick_d;
    logic          done_q, done_d;
    logic [PW-1:0] presc_q, presc_d;
    // Set the cycle after a tick: the table now sees the new address,
    // so phrase_id is captured one cycle later and strobed with it.
    logic          load_q, load_d;

    logic tick;
    logic phrase_end;
    logic song_end;

    assign tick       = (state_q == PLAY) && !pause && (presc_q == PRESC_MAX);
    assign phrase_end = (step_q == STEP_MAX);
    assign song_end   = tick && phrase_end && (address_q == LAST_A);

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (start) state_d = PRIME;
            PRIME:   state_d = PLAY;
            PLAY: begin
`ifndef PHRASE_SEQ_LOOP_EN
                if (song_end) state_d = IDLE;
`endif
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs
    always_comb begin
        playing   = (state_q != IDLE);
        address   = address_q;
        phrase_id = phrase_id_q;
        step      = step_q;
        step_tick = step_tick_q;
        done      = done_q;
    end

    // Datapath next values
    always_comb begin
        address_d   = address_q;
        phrase_id_d = phrase_id_q;
        step_d      = step_q;
        presc_d     = presc_q;
        step_tick_d = 1'b0;
        done_d      = 1'b0;
        load_d      = 1'b0;
        unique case (state_q)
            IDLE: begin
                address_d   = start ? 8'd1 : 8'd0;
                phrase_id_d = 5'd0;
                step_d      = 4'd0;
                presc_d     = '0;
            end
            PRIME: begin
                // Prescaler already runs here so the first PLAY tick
                // lands a full TICK_DIV after the PRIME strobe.
                phrase_id_d = db_entry;
                step_tick_d = 1'b1;
                presc_d     = (presc_q == PRESC_MAX) ? '0 : presc_q + 1'b1;
            end
            PLAY: begin
                if (load_q) begin
                    phrase_id_d = db_entry;
                    step_tick_d = 1'b1;
                end
                if (!pause) begin
                    presc_d = (presc_q == PRESC_MAX) ? '0 : presc_q + 1'b1;
                end
                if (song_end) begin
                    step_d = 4'd0;
                    done_d = 1'b1;
`ifdef PHRASE_SEQ_LOOP_EN
                    address_d = LOOP_A;
                    load_d    = 1'b1;
`else
                    address_d = 8'd0;
`endif
                end else if (tick && phrase_end) begin
                    step_d    = 4'd0;
                    address_d = address_q + 8'd1;
                    load_d    = 1'b1;
                end else if (tick) begin
                    step_d = (step_q + 4'd1) & STEP_MAX;
                    load_d = 1'b1;
                end
            end
            default: begin
                address_d   = 8'd0;
                phrase_id_d = 5'd0;
                step_d      = 4'd0;
                presc_d     = '0;
            end
        endcase
    end

    // Datapath registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            address_q   <= 8'd0;
            phrase_id_q <= 5'd0;
            step_q      <= 4'd0;
            step_tick_q <= 1'b0;
            done_q      <= 1'b0;
            presc_q     <= '0;
            load_q      <= 1'b0;
        end else begin
            address_q   <= address_d;
            phrase_id_q <= phrase_id_d;
            step_q      <= step_d;
            step_tick_q <= step_tick_d;
            done_q      <= done_d;
            presc_q     <= presc_d;
            load_q      <= load_d;
        end
    end

endmodule
